// File: rtl/shader_sequencer.sv
// Shader program sequencer: steps the instruction PC from 0 to a latched last PC,
// honouring datapath hold and abort. Optional multi-pass looping under SHADER_SEQ_LOOP_EN.
module shader_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] prog_last,
    input  logic       hold,
    input  logic       abort,
`ifdef SHADER_SEQ_LOOP_EN
    input  logic [3:0] loop_cnt,
`endif
    output logic [3:0] pc,
    output logic       issue_valid,
    output logic       busy,
    output logic       done,
    output logic [4:0] issued_cnt
);

    // Handshake: issue_valid marks the cycle in which the decoder's registered fields for the
    // PC presented one cycle earlier may be executed; there is no back-pressure other than hold.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t     state;
    logic [3:0] last;
`ifdef SHADER_SEQ_LOOP_EN
    logic [3:0] passes_left;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= 4'd0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            issued_cnt  <= 5'd0;
            last        <= 4'd0;
`ifdef SHADER_SEQ_LOOP_EN
            passes_left <= 4'd0;
`endif
        end else begin
            // The decoder registers the PC, so a non-stalled RUN cycle issues on the next cycle.
            issue_valid <= (state == RUN) && !hold && !abort;
            done        <= 1'b0;
            if (issue_valid && (issued_cnt != 5'd31)) begin
                issued_cnt <= issued_cnt + 5'd1;
            end

            case (state)
                IDLE: begin
                    pc <= 4'd0;
                    if (start) begin
                        state      <= RUN;
                        last       <= prog_last;
                        issued_cnt <= 5'd0;
                        busy       <= 1'b1;
`ifdef SHADER_SEQ_LOOP_EN
                        passes_left <= loop_cnt;
`endif
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        pc    <= 4'd0;
                        busy  <= 1'b0;
                    end else if (!hold) begin
                        if (pc == last) begin
`ifdef SHADER_SEQ_LOOP_EN
                            if (passes_left != 4'd0) begin
                                passes_left <= passes_left - 4'd1;
                                pc          <= 4'd0;
                            end else begin
                                state <= DRAIN;
                            end
`else
                            state <= DRAIN;
`endif
                        end else begin
                            pc <= pc + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    state <= (abort) ? IDLE : DONE;
                    done  <= !abort;
                    busy  <= 1'b0;
                    pc    <= 4'd0;
                end
                DONE: begin
                    state <= IDLE;
                    pc    <= 4'd0;
                end
                default: begin
                    state <= IDLE;
                    pc    <= 4'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shader_sequencer.sv
// Bench for shader_sequencer: directed scenarios plus random traffic, checked every cycle
// against a progress-counter reference model and an issued-PC scoreboard queue.
module tb_shader_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] prog_last;
    logic       hold;
    logic       abort;
`ifdef SHADER_SEQ_LOOP_EN
    logic [3:0] loop_cnt;
    localparam bit loop_en = 1'b1;
`else
    localparam bit loop_en = 1'b0;
`endif
    logic [3:0] pc;
    logic       issue_valid;
    logic       busy;
    logic       done;
    logic [4:0] issued_cnt;

    shader_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_last   (prog_last),
        .hold        (hold),
        .abort       (abort),
`ifdef SHADER_SEQ_LOOP_EN
        .loop_cnt    (loop_cnt),
`endif
        .pc          (pc),
        .issue_valid (issue_valid),
        .busy        (busy),
        .done        (done),
        .issued_cnt  (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Reference model: a program is n = (last+1)*passes non-stalled RUN cycles, then one
    // drain cycle (tail 1) and one done cycle (tail 2).
    bit         m_active;
    int         m_k, m_n, m_len, m_tail, m_cnt;
    logic [3:0] m_last;
    bit         m_iv;
    logic [3:0] exp_q[$];
    logic [3:0] prev_pc;

    int         cyc, n_done, done_cyc;
    logic [3:0] pc_log[0:63];
    logic       iv_log[0:63];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_iv     = 1'b0;
        m_cnt    = 0;
        m_tail   = 0;
        exp_q.delete();
    endtask

    task automatic model_update(input logic s, input logic [3:0] pl, input logic h,
                                input logic a, input logic [3:0] lc);
        bit iv_next;
        iv_next = m_active && (m_tail == 0) && !h && !a;
        if (m_iv && m_cnt != 31) m_cnt++;
        if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_k      = 0;
                m_tail   = 0;
                m_last   = pl;
                m_len    = int'(pl) + 1;
                m_n      = m_len * (loop_en ? int'(lc) + 1 : 1);
                m_cnt    = 0;
                exp_q.delete();
                for (int i = 0; i < m_n; i++) exp_q.push_back(4'(i % m_len));
            end
        end else if (m_tail == 0) begin
            if (a) begin
                m_active = 1'b0;
                exp_q.delete();
            end else if (!h) begin
                m_k++;
                if (m_k == m_n) m_tail = 1;
            end
        end else if (m_tail == 1) begin
            if (a) begin
                m_active = 1'b0;
                exp_q.delete();
            end else begin
                m_tail = 2;
            end
        end else begin
            m_active = 1'b0;
        end
        m_iv = iv_next;
    endtask

    task automatic check_outputs();
        logic [3:0] e_pc;
        logic       e_busy, e_done;
        e_pc = 4'd0; e_busy = 1'b0; e_done = 1'b0;
        if (m_active && m_tail == 0) begin
            e_pc = 4'(m_k % m_len); e_busy = 1'b1;
        end else if (m_active && m_tail == 1) begin
            e_pc = m_last; e_busy = 1'b1;
        end else if (m_active && m_tail == 2) begin
            e_done = 1'b1;
        end
        chk("pc", 8'(pc), 8'(e_pc));
        chk("busy", 8'(busy), 8'(e_busy));
        chk("done", 8'(done), 8'(e_done));
        chk("issue_valid", 8'(issue_valid), 8'(m_iv));
        chk("issued_cnt", 8'(issued_cnt), 8'(m_cnt));
        if (issue_valid === 1'b1) begin
            if (exp_q.size() > 0) chk("issued_pc", 8'(prev_pc), 8'(exp_q.pop_front()));
            else chk("issue_extra", 8'(issue_valid), 8'd0);
        end
        if (done === 1'b1) chk("queue_empty_at_done", 8'(exp_q.size()), 8'd0);
        prev_pc = pc;
    endtask

    task automatic tick(input logic s, input logic [3:0] pl, input logic h,
                        input logic a, input logic [3:0] lc);
        start = s; prog_last = pl; hold = h; abort = a;
`ifdef SHADER_SEQ_LOOP_EN
        loop_cnt = lc;
`endif
        @(negedge clk);
        check_outputs();
        if (cyc < 64) begin
            pc_log[cyc] = pc;
            iv_log[cyc] = issue_valid;
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        @(posedge clk);
        model_update(s, pl, h, a, lc);
        cyc++;
        #1;
    endtask

    task automatic begin_test();
        cyc = 0; n_done = 0; done_cyc = -1;
        for (int i = 0; i < 64; i++) begin
            pc_log[i] = 4'hx;
            iv_log[i] = 1'bx;
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; prog_last = 4'd0; hold = 1'b0; abort = 1'b0;
`ifdef SHADER_SEQ_LOOP_EN
        loop_cnt = 4'd0;
`endif
        prev_pc = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", 8'(pc), 8'd0);
        chk("rst_issue_valid", 8'(issue_valid), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_issued_cnt", 8'(issued_cnt), 8'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Plain 4-instruction program.
        begin_test();
        tick(1'b1, 4'd3, 1'b0, 1'b0, 4'd0);
        idle_ticks(8);
        for (int i = 1; i <= 4; i++) chk("t1_pc_seq", 8'(pc_log[i]), 8'(i - 1));
        chk("t1_iv_c1", 8'(iv_log[1]), 8'd0);
        for (int i = 2; i <= 5; i++) chk("t1_iv_on", 8'(iv_log[i]), 8'd1);
        chk("t1_iv_c6", 8'(iv_log[6]), 8'd0);
        chk("t1_done_cyc", 8'(done_cyc), 8'd6);
        chk("t1_n_done", 8'(n_done), 8'd1);
        chk("t1_cnt", 8'(issued_cnt), 8'd4);

        // Two hold cycles while PC 1 is presented.
        begin_test();
        tick(1'b1, 4'd3, 1'b0, 1'b0, 4'd0);
        tick(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        tick(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
        tick(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
        idle_ticks(8);
        for (int i = 2; i <= 4; i++) chk("t2_pc_held", 8'(pc_log[i]), 8'd1);
        chk("t2_iv_gap3", 8'(iv_log[3]), 8'd0);
        chk("t2_iv_gap4", 8'(iv_log[4]), 8'd0);
        chk("t2_iv_pc1", 8'(iv_log[5]), 8'd1);
        chk("t2_done_cyc", 8'(done_cyc), 8'd8);
        chk("t2_cnt", 8'(issued_cnt), 8'd4);

        // Abort while PC 2 is presented.
        begin_test();
        tick(1'b1, 4'd7, 1'b0, 1'b0, 4'd0);
        tick(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        tick(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        tick(1'b0, 4'd0, 1'b1, 1'b1, 4'd0);
        idle_ticks(6);
        chk("t3_pc_at_abort", 8'(pc_log[3]), 8'd2);
        chk("t3_pc_after", 8'(pc_log[4]), 8'd0);
        chk("t3_iv_after", 8'(iv_log[4]), 8'd0);
        chk("t3_n_done", 8'(n_done), 8'd0);
        chk("t3_cnt", 8'(issued_cnt), 8'd2);

        // Asynchronous reset mid-run, then a start on the first edge after release.
        begin_test();
        tick(1'b1, 4'd9, 1'b0, 1'b0, 4'd0);
        idle_ticks(5);
        start = 1'b0; hold = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("t4_pc_before_rst", 8'(pc), 8'd5);
        #1 rst = 1'b1;
        #1;
        chk("t4_async_pc", 8'(pc), 8'd0);
        chk("t4_async_iv", 8'(issue_valid), 8'd0);
        chk("t4_async_busy", 8'(busy), 8'd0);
        chk("t4_async_done", 8'(done), 8'd0);
        chk("t4_async_cnt", 8'(issued_cnt), 8'd0);
        #1 rst = 1'b0;
        model_reset();
        begin_test();
        start = 1'b1; prog_last = 4'd2;
        @(posedge clk);
        model_update(1'b1, 4'd2, 1'b0, 1'b0, 4'd0);
        cyc++;
        #1;
        idle_ticks(7);
        chk("t4_pc_c1", 8'(pc_log[1]), 8'd0);
        chk("t4_done_cyc", 8'(done_cyc), 8'd5);
        chk("t4_cnt", 8'(issued_cnt), 8'd3);

        // Start held across two single-instruction programs; busy/done-time starts are ignored.
        begin_test();
        for (int i = 0; i < 8; i++) tick(1'b1, 4'd0, 1'b0, 1'b0, 4'd0);
        idle_ticks(6);
        chk("t5_n_done", 8'(n_done), 8'd2);
        chk("t5_last_done", 8'(done_cyc), 8'd7);
        chk("t5_idle_gap_pc", 8'(pc_log[4]), 8'd0);
        chk("t5_cnt", 8'(issued_cnt), 8'd1);

        // Longest single-pass program stops at PC 15.
        begin_test();
        tick(1'b1, 4'd15, 1'b0, 1'b0, 4'd0);
        idle_ticks(20);
        chk("t6_drain_pc", 8'(pc_log[17]), 8'd15);
        chk("t6_done_cyc", 8'(done_cyc), 8'd18);
        chk("t6_cnt", 8'(issued_cnt), 8'd16);

`ifdef SHADER_SEQ_LOOP_EN
        // Three passes over a two-instruction program.
        begin_test();
        tick(1'b1, 4'd1, 1'b0, 1'b0, 4'd2);
        idle_ticks(10);
        for (int i = 1; i <= 6; i++) chk("t7_pc_seq", 8'(pc_log[i]), 8'((i - 1) % 2));
        for (int i = 2; i <= 7; i++) chk("t7_iv_on", 8'(iv_log[i]), 8'd1);
        chk("t7_n_done", 8'(n_done), 8'd1);
        chk("t7_cnt", 8'(issued_cnt), 8'd6);
`endif

        // Random traffic.
        begin_test();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0),
                 4'($urandom_range(0, 3)));
        end
        idle_ticks(80);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
